// File: rtl/ram_fifo_pkg.sv
// Shared defaults for the RAM-backed byte FIFO controller.
package ram_fifo_pkg;

    localparam int DEF_ADDR_W   = 9;
    localparam int DEF_DATA_W   = 8;
    localparam int DEPTH        = 2 ** DEF_ADDR_W;
    localparam int OB_DEPTH     = 2;
    localparam int DEF_AF_LEVEL = 496;
    localparam int DEF_AE_LEVEL = 16;

endpackage

// File: rtl/ram_fifo_outbuf.sv
// Two-entry output buffer fed by RAM read data; slot0 is always the head byte.
module ram_fifo_outbuf
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              capture,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              pop,
    output logic [1:0]        ob_cnt,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] slot0;
    logic [DATA_W-1:0] slot1;
    logic              cap_to_head;

    // A capture lands in whichever slot is the first free one after this cycle's pop.
    assign cap_to_head = (ob_cnt == 2'd0) || ((ob_cnt == 2'd1) && pop);
    assign head        = slot0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0  <= '0;
            slot1  <= '0;
            ob_cnt <= '0;
        end else if (flush) begin
            ob_cnt <= '0;
        end else begin
            if (pop) begin
                slot0 <= slot1;
            end
            if (capture) begin
                if (cap_to_head) begin
                    slot0 <= cap_data;
                end else begin
                    slot1 <= cap_data;
                end
            end
            ob_cnt <= ob_cnt + 2'(capture) - 2'(pop);
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Single-clock FIFO controller over a 512x8 dual-port RAM (port A writes, port B reads).
// Optional FIFO_WATERMARK_EN adds registered almost_full / almost_empty flags.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
`ifdef FIFO_WATERMARK_EN
    ,
    parameter int AF_LEVEL = DEF_AF_LEVEL,
    parameter int AE_LEVEL = DEF_AE_LEVEL
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_data_a,
    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [DATA_W-1:0] ram_data_b,
    output logic              ram_we_b,
    input  logic [DATA_W-1:0] ram_q_b
`ifdef FIFO_WATERMARK_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   mem_cnt;
    logic              rd_pend;
    logic [1:0]        ob_cnt;
    logic [2:0]        ob_load;
    logic              push;
    logic              pop;
    logic              issue;

    // mem_cnt never exceeds DEPTH, so its top bit alone marks a full RAM.
    assign in_ready  = ~mem_cnt[ADDR_W] & ~flush;
    assign push      = in_valid & in_ready;
    assign out_valid = (ob_cnt != 2'd0);
    assign pop       = out_valid & out_ready;

    // Buffer occupancy including the read in flight, net of this cycle's pop.
    assign ob_load = {1'b0, ob_cnt} + {2'b00, rd_pend} - {2'b00, pop};
    assign issue   = (mem_cnt != '0) & (ob_load < 3'(OB_DEPTH)) & ~flush;

    assign ram_addr_a = wr_ptr;
    assign ram_data_a = in_data;
    assign ram_we_a   = push;
    assign ram_addr_b = rd_ptr;
    assign ram_data_b = '0;
    assign ram_we_b   = 1'b0;

    assign count = mem_cnt + (ADDR_W+1)'(rd_pend) + (ADDR_W+1)'(ob_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            rd_pend <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            rd_pend <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + ADDR_W'(push);
            rd_ptr  <= rd_ptr + ADDR_W'(issue);
            mem_cnt <= mem_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(issue);
            rd_pend <= issue;
        end
    end

    // RAM port B is registered, so data for a read issued last cycle is on ram_q_b now.
    ram_fifo_outbuf #(
        .DATA_W (DATA_W)
    ) u_outbuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .capture  (rd_pend),
        .cap_data (ram_q_b),
        .pop      (pop),
        .ob_cnt   (ob_cnt),
        .head     (out_data)
    );

`ifdef FIFO_WATERMARK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count >= (ADDR_W+1)'(AF_LEVEL));
            almost_empty <= (count <= (ADDR_W+1)'(AE_LEVEL));
        end
    end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 512x8 dual-port RAM behind it.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic       ram_we_a, ram_we_b;
    logic [7:0] in_data, out_data, ram_data_a, ram_data_b, ram_q_b;
    logic [9:0] count;
    logic [8:0] ram_addr_a, ram_addr_b;
`ifdef FIFO_WATERMARK_EN
    logic       almost_full, almost_empty;
`endif

    logic [7:0] ram [0:511];
    logic [7:0] q [$];
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count      (count),
        .ram_addr_a (ram_addr_a),
        .ram_data_a (ram_data_a),
        .ram_we_a   (ram_we_a),
        .ram_addr_b (ram_addr_b),
        .ram_data_b (ram_data_b),
        .ram_we_b   (ram_we_b),
        .ram_q_b    (ram_q_b)
`ifdef FIFO_WATERMARK_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    always @(posedge clk) begin
        if (ram_we_a) ram[ram_addr_a] <= ram_data_a;
        ram_q_b <= ram[ram_addr_b];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference queue: order and occupancy of every byte the FIFO should hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            chk("count", 32'(count), 32'(q.size()));
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (q.size() == 0) chk("underflow", 32'd1, 32'd0);
                    else               chk("data", 32'(out_data), 32'(q.pop_front()));
                end
                if (in_valid && in_ready) q.push_back(in_data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, pops, bub, k, first;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_we_b", 32'(ram_we_b), 32'd0);
`ifdef FIFO_WATERMARK_EN
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_ae", 32'(almost_empty), 32'd1);
`endif
        @(posedge clk); #1 rst_n = 1'b1;

        // three bytes back to back, downstream always ready
        @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b1;
        @(posedge clk); #1 in_data = 8'h22;
        @(posedge clk); #1 in_data = 8'h33;
        @(negedge clk); chk("lat_e1_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk); chk("b0_valid", 32'(out_valid), 32'd1); chk("b0_data", 32'(out_data), 32'h11);
        @(negedge clk); chk("b1_valid", 32'(out_valid), 32'd1); chk("b1_data", 32'(out_data), 32'h22);
        @(negedge clk); chk("b2_valid", 32'(out_valid), 32'd1); chk("b2_data", 32'(out_data), 32'h33);
        @(negedge clk); chk("b3_valid", 32'(out_valid), 32'd0);

        // fill to capacity with downstream stalled
        @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h00;
        n = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (!in_ready) break;
            n++;
            @(posedge clk); #1 in_data = 8'(n);
        end
        chk("fill_accepts", 32'(n), 32'd514);
        chk("fill_count", 32'(count), 32'd514);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_head", 32'(out_data), 32'h00);
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;

        // drain from full
        pops = 0; bub = 0;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (count == 10'd0) break;
            if (out_valid) pops++;
            else           bub++;
        end
        chk("drain_pops", 32'(pops), 32'd514);
        chk("drain_bubbles", 32'(bub), 32'd0);
        chk("drain_count", 32'(count), 32'd0);

        // continuous streaming across several pointer wraps
        @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h5A;
        k = 0; pops = 0; bub = 0; first = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (out_valid) begin
                first = 1;
                pops++;
            end else if (first != 0 && pops < 2000) begin
                bub++;
            end
            if (in_valid && in_ready) k++;
            if (pops >= 2000) break;
            @(posedge clk); #1;
            in_data = 8'(k) ^ 8'h5A;
            if (k >= 2000) in_valid = 1'b0;
        end
        chk("stream_pushes", 32'(k), 32'd2000);
        chk("stream_pops", 32'(pops), 32'd2000);
        chk("stream_bubbles", 32'(bub), 32'd0);
        @(negedge clk); chk("stream_count", 32'(count), 32'd0);

        // random back-pressure, then flush mid-stream
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1 flush = 1'b1; in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
        @(negedge clk); chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1 flush = 1'b0; in_data = 8'hA5;
        @(negedge clk);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1 in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("post_flush_valid", 32'(out_valid), 32'd1);
        chk("post_flush_data", 32'(out_data), 32'hA5);

        // asynchronous reset in the middle of traffic
        @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("areset_count", 32'(count), 32'd0);
        chk("areset_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("areset_in_ready", 32'(in_ready), 32'd1);

`ifdef FIFO_WATERMARK_EN
        @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h01; out_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (in_ready) n++;
            @(posedge clk); #1;
            in_data = 8'(n + 1);
            if (n >= 496) begin
                in_valid = 1'b0;
                break;
            end
        end
        @(negedge clk);
        chk("wm_count", 32'(count), 32'd496);
        chk("wm_af_lag", 32'(almost_full), 32'd0);
        @(negedge clk); chk("wm_af", 32'(almost_full), 32'd1);
        @(posedge clk); #1 out_ready = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (count == 10'd17) begin
                @(posedge clk); #1 out_ready = 1'b0;
                break;
            end
        end
        @(negedge clk);
        chk("wm_drain_count", 32'(count), 32'd16);
        chk("wm_ae_lag", 32'(almost_empty), 32'd0);
        @(negedge clk); chk("wm_ae", 32'(almost_empty), 32'd1);
        chk("wm_af_clear", 32'(almost_full), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
